// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial comparator driver: FSM states and the captured
// comparator result.
package serial_cmp_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, RESULT} state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        logic err;
    } cmp_result_t;

    // A healthy comparator raises exactly one of its three flags.
    function automatic logic flags_not_one_hot(input logic lt, input logic eq, input logic gt);
        return !((lt & !eq & !gt) | (!lt & eq & !gt) | (!lt & !eq & gt));
    endfunction

endpackage

// File: rtl/serial_shift_out.sv
// Loadable shift register presenting one operand bit per cycle, with an
// optional bit counter that flags the final bit of the word.
module serial_shift_out
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit USE_COUNTER = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= data;
        end else if (shift) begin
            sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        end
    end

    assign bit_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    // Only one lane needs to track position; the other lane omits the counter.
    generate
        if (USE_COUNTER) begin : g_counter
            logic [CW-1:0] count;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count <= '0;
                end else if (load) begin
                    count <= '0;
                end else if (shift) begin
                    count <= count + 1'b1;
                end
            end

            assign last = (count == CW'(WIDTH - 1));
        end else begin : g_no_counter
            assign last = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/serial_compare_driver.sv
// Word-level front end for the bit-serial comparators: accepts an operand
// pair, clears the comparator, shifts both words out and returns the flags.
module serial_compare_driver
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_clr,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_last,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic             out_err
);

    state_t      state;
    state_t      state_next;
    cmp_result_t result;

    logic accept;
    logic shift_en;
    logic a_bit;
    logic b_bit;
    logic a_last;
    logic unused_b_last;

    serial_shift_out #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .USE_COUNTER(1'b1)
    ) u_shift_a (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (shift_en),
        .data   (in_a),
        .bit_out(a_bit),
        .last   (a_last)
    );

    serial_shift_out #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .USE_COUNTER(1'b0)
    ) u_shift_b (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .shift  (shift_en),
        .data   (in_b),
        .bit_out(b_bit),
        .last   (unused_b_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The CLEAR cycle lets the comparator's synchronous reset take effect
    // before the first bit is presented.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        shift_en   = 1'b0;
        ser_clr    = 1'b0;
        ser_valid  = 1'b0;
        ser_a      = 1'b0;
        ser_b      = 1'b0;
        ser_last   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                ser_clr    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_a     = a_bit;
                ser_b     = b_bit;
                ser_last  = a_last;
                shift_en  = 1'b1;
                if (a_last) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Comparator flags are only meaningful once the final bit is on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (state == SHIFT && a_last) begin
            result <= '{lt:  cmp_lt,
                        eq:  cmp_eq,
                        gt:  cmp_gt,
                        err: flags_not_one_hot(cmp_lt, cmp_eq, cmp_gt)};
        end
    end

    assign out_lt  = result.lt;
    assign out_eq  = result.eq;
    assign out_gt  = result.gt;
    assign out_err = result.err;

endmodule

// File: tb/tb_serial_compare_driver.sv
// Drives an MSB-first and an LSB-first driver in lockstep, each attached to a
// behavioural serial comparator, and checks them against word-level expectations.
module tb_serial_compare_driver;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic out_ready = 1'b0;
    logic force_err = 1'b0;

    logic [1:0] in_ready, ser_clr, ser_valid, ser_a, ser_b, ser_last;
    logic [1:0] cmp_lt, cmp_eq, cmp_gt;
    logic [1:0] out_valid, out_lt, out_eq, out_gt, out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_compare_driver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_a(in_a), .in_b(in_b),
        .ser_clr(ser_clr[0]), .ser_valid(ser_valid[0]), .ser_a(ser_a[0]), .ser_b(ser_b[0]),
        .ser_last(ser_last[0]),
        .cmp_lt(cmp_lt[0]), .cmp_eq(cmp_eq[0]), .cmp_gt(cmp_gt[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_lt(out_lt[0]), .out_eq(out_eq[0]), .out_gt(out_gt[0]), .out_err(out_err[0])
    );

    serial_compare_driver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_a(in_a), .in_b(in_b),
        .ser_clr(ser_clr[1]), .ser_valid(ser_valid[1]), .ser_a(ser_a[1]), .ser_b(ser_b[1]),
        .ser_last(ser_last[1]),
        .cmp_lt(cmp_lt[1]), .cmp_eq(cmp_eq[1]), .cmp_gt(cmp_gt[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_lt(out_lt[1]), .out_eq(out_eq[1]), .out_gt(out_gt[1]), .out_err(out_err[1])
    );

    // Behavioural comparator: accumulates the bits seen so far as integers and
    // compares the partial words, which equals the full compare on the last bit.
    int acc_a[2];
    int acc_b[2];
    int nbits[2];
    int pa[2];
    int pb[2];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            pa[d] = 0;
            pb[d] = 0;
            cmp_lt[d] = 1'b0;
            cmp_eq[d] = 1'b0;
            cmp_gt[d] = 1'b0;
            if (d == 0) begin
                pa[d] = (acc_a[d] << 1) | int'(ser_a[d]);
                pb[d] = (acc_b[d] << 1) | int'(ser_b[d]);
            end else begin
                pa[d] = acc_a[d] | (int'(ser_a[d]) << nbits[d]);
                pb[d] = acc_b[d] | (int'(ser_b[d]) << nbits[d]);
            end
            if (force_err && nbits[d] == W - 1) begin
                cmp_lt[d] = 1'b1;
                cmp_gt[d] = 1'b1;
            end else begin
                cmp_lt[d] = pa[d] < pb[d];
                cmp_eq[d] = pa[d] == pb[d];
                cmp_gt[d] = pa[d] > pb[d];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || ser_clr[d]) begin
                acc_a[d] <= 0;
                acc_b[d] <= 0;
                nbits[d] <= 0;
            end else if (ser_valid[d]) begin
                acc_a[d] <= pa[d];
                acc_b[d] <= pb[d];
                nbits[d] <= nbits[d] + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outVec(input int d);
        return {ser_clr[d], ser_valid[d], ser_a[d], ser_b[d], ser_last[d],
                out_valid[d], out_lt[d], out_eq[d], out_gt[d], out_err[d]};
    endfunction

    // One full operation: accept, clear, WIDTH bits, result held for `hold`
    // cycles of backpressure with ignored in_valid, then released.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic inj, input int hold);
        logic [3:0] exp_flags;
        logic [W-1:0] ea, eb;
        int idx;
        exp_flags = inj ? 4'b1011 : {a < b, a == b, a > b, 1'b0};
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkOutput("idle_ready", in_ready[d], 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        force_err = inj;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = ~a;
        in_b = W'($urandom);
        for (int d = 0; d < 2; d++) begin
            checkOutput("clr_cycle", {ser_clr[d], ser_valid[d], in_ready[d]}, 3'b100);
        end
        ea = a;
        eb = b;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                idx = (d == 0) ? (W - 1 - i) : i;
                checkOutput($sformatf("bit%0d_d%0d", i, d),
                            {ser_clr[d], ser_valid[d], ser_a[d], ser_b[d], ser_last[d], out_valid[d]},
                            {1'b0, 1'b1, ea[idx], eb[idx], (i == W - 1), 1'b0});
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("result_valid", {out_valid[d], ser_valid[d], in_ready[d]}, 3'b100);
            checkOutput($sformatf("flags_d%0d", d),
                        {out_lt[d], out_eq[d], out_gt[d], out_err[d]}, exp_flags);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a = W'($urandom);
            in_b = W'($urandom);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checkOutput("hold_state", {out_valid[d], in_ready[d], ser_clr[d]}, 3'b100);
                checkOutput("hold_flags", {out_lt[d], out_eq[d], out_gt[d], out_err[d]}, exp_flags);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        force_err = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checkOutput("release", {out_valid[d], in_ready[d], ser_clr[d]}, 3'b010);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_outputs", outVec(d), 10'd0);
            checkOutput("reset_ready", in_ready[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkOutput("post_reset_ready", in_ready[d], 1);

        applyStimulus(8'h5A, 8'h5A, 1'b0, 0);
        applyStimulus(8'h80, 8'h7F, 1'b0, 0);
        applyStimulus(8'h01, 8'h02, 1'b0, 5);
        applyStimulus(8'h33, 8'hC4, 1'b1, 1);

        // rst wins over a simultaneous in_valid
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_vs_valid", {in_ready[d], ser_clr[d], ser_valid[d]}, 3'b100);
        end

        // reset pulsed during the third bit aborts the operation
        in_a = 8'hAB;
        in_b = 8'hCD;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) checkOutput("third_bit_live", ser_valid[d], 1);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("abort_outputs", outVec(d), 10'd0);
            checkOutput("abort_ready", in_ready[d], 0);
        end
        rst = 1'b0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checkOutput("abort_quiet", {out_valid[d], ser_valid[d], in_ready[d]}, 3'b001);
            end
        end
        applyStimulus(8'h10, 8'h20, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            applyStimulus(ra, rb, ($urandom_range(0, 5) == 0), $urandom_range(0, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_compare_driver.md
# serial_compare_driver

Transmit side for the serial comparators. Accepts a pair of parallel operands over a valid/ready handshake and clears the downstream serial comparator. It then shifts both operands out one bit per cycle, MSB-first or LSB-first, and captures the comparator's flags on the final bit. The result is returned over a second valid/ready handshake. It sits between a parallel producer and a serial_comparator_* instance, so the bit-serial comparators can be used from word-level logic.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥1
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first (pairs with the MSB-first comparator); 0 = emit bit 0 first (pairs with the LSB-first comparator)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  driver idle, will accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- ser_clr  out  1  one-cycle clear for the comparator; integrator drives comparator rst = rst | ser_clr
- ser_valid  out  1  ser_a/ser_b carry a live bit this cycle
- ser_a  out  1  current bit of A
- ser_b  out  1  current bit of B
- ser_last  out  1  final bit of the word this cycle
- cmp_lt  in  1  comparator a_less_b (combinational from current bit)
- cmp_eq  in  1  comparator a_eq_b
- cmp_gt  in  1  comparator a_greater_b
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_lt  out  1  registered result flag
- out_eq  out  1  registered result flag
- out_gt  out  1  registered result flag
- out_err  out  1  captured flags were not one-hot

## Operation
- FSM states: IDLE, CLEAR, SHIFT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid: load in_a/in_b into the shift registers, bit counter := 0, go to CLEAR.
- CLEAR:
  - ser_clr=1, ser_valid=0, go to SHIFT.
  - This cycle is required because the comparator reset is synchronous and its outputs are combinational on its previous-state registers.
- SHIFT:
  - ser_valid=1.
  - ser_a/ser_b = MSB of the shift registers when MSB_FIRST=1, otherwise LSB.
  - Shift by one every cycle; counter increments.
  - ser_last=1 when counter==WIDTH-1.
  - On ser_last, register cmp_lt/eq/gt into out_lt/eq/gt.
  - On ser_last, out_err := !(exactly one of cmp_* high).
  - Then go to RESULT.
- RESULT:
  - out_valid=1; flags held stable.
  - On out_ready, go to IDLE.
  - New in_valid is ignored here because in_ready=0.
- Outputs ser_a, ser_b and ser_last are 0 whenever ser_valid=0.
- cmp_* are sampled only in the ser_last cycle and ignored in all other cycles.
- Bit counter width is $clog2(WIDTH+1). WIDTH=1 goes CLEAR, then one SHIFT cycle with ser_last=1, then RESULT.

## Timing
- Reset:
  - Required state after reset: state=IDLE; ser_clr, ser_valid, ser_a, ser_b, ser_last, out_valid, out_lt, out_eq, out_gt and out_err all 0.
  - in_ready is 0 while rst is high and 1 from the first cycle after.
- Reset mid-operation, in any state: abort the operation with no out_valid; all outputs take their reset values on the next edge.
- Latency, counting the accept edge as cycle 0:
  - ser_clr in cycle 1.
  - Bits in cycles 2 … WIDTH+1.
  - out_valid from cycle WIDTH+2.
- Throughput: minimum one operation per WIDTH+3 cycles, reached when out_ready is held high.
- If in_valid and rst are high together, rst wins and nothing is loaded.
- in_a/in_b are sampled only at the accept edge; later changes do not affect the word in flight.

## Structure
- Package serial_cmp_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, CLEAR, SHIFT, RESULT}
  - typedef struct packed {lt, eq, gt, err} cmp_result_t
- Sub-module serial_shift_out (parameters WIDTH, MSB_FIRST):
  - Loadable shift register plus bit counter.
  - Outputs the current bit and last.
  - Instantiated twice, for A and B; only one counter is kept, the B instance's last output is left unused.
- Top-level holds the FSM, result register and handshake logic.

## Test plan
- WIDTH=8, MSB_FIRST=1, driving serial_comparator_most_significant_first, a=0x5A, b=0x5A -> ser_a sequence 0,1,0,1,1,0,1,0 in cycles 2–9; out_valid at cycle 10 with out_eq=1, out_lt=0, out_gt=0, out_err=0.
- MSB_FIRST=1, a=0x80, b=0x7F -> out_gt=1; ser_last high only in cycle 9.
- MSB_FIRST=0, driving serial_comparator_least_significant_first, a=0x01, b=0x02 -> ser_a sequence 1,0,0,0,0,0,0,0 and out_lt=1.
- Result backpressure: out_ready held low 5 cycles after out_valid -> out_valid and flags stable, in_ready=0, new in_valid ignored. With out_ready=1, out_valid drops on the next edge, in_ready=1, and the next op completes correctly.
- Reset during SHIFT: rst pulsed during the 3rd bit -> all outputs 0 on the next edge, no out_valid; a following op a=0x10, b=0x20 gives out_lt=1.
- Comparator stub forcing cmp_lt=cmp_gt=1 on the last bit -> out_err=1.
